iob_axi2iob_sub: RTL and testbench



---
 rtl/iob_axi2iob_sub.sv | 254 +++++++++++++++++++++++++
 tb/tb_iob_axi2iob_sub.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi2iob_sub.sv
// AXI4 subordinate that serialises read/write bursts into single-word IOB native transactions.
// One transaction at a time; AR/AW arbitration alternates when both are requesting.
module iob_axi2iob_sub #(
    parameter int unsigned AXI_ID_W   = 1,
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_LEN_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cke_i,
    // AR
    input  logic [AXI_ADDR_W-3:0]   axi_araddr_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [2:0]              axi_arprot_i,
    input  logic                    axi_arlock_i,
    input  logic [3:0]              axi_arcache_i,
    input  logic [3:0]              axi_arqos_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    // R
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    // AW
    input  logic [AXI_ADDR_W-3:0]   axi_awaddr_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [2:0]              axi_awprot_i,
    input  logic                    axi_awlock_i,
    input  logic [3:0]              axi_awcache_i,
    input  logic [3:0]              axi_awqos_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    // W
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    // B
    output logic [1:0]              axi_bresp_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    // IOB manager
    output logic                    iob_valid_o,
    output logic [AXI_ADDR_W-3:0]   iob_addr_o,
    output logic [AXI_DATA_W-1:0]   iob_wdata_o,
    output logic [AXI_DATA_W/8-1:0] iob_wstrb_o,
    input  logic                    iob_ready_i,
    input  logic                    iob_rvalid_i,
    input  logic [AXI_DATA_W-1:0]   iob_rdata_i
);

    localparam int unsigned WordAddrW = AXI_ADDR_W - 2;
    localparam int unsigned StrbW     = AXI_DATA_W / 8;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StRdResp,
        StWrData,
        StWrReq,
        StWrResp
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_grant_wr_q, last_grant_wr_d;
    logic [AXI_ID_W-1:0]    id_q, id_d;
    logic [WordAddrW-1:0]   addr_q, addr_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d;
    logic [AXI_LEN_W-1:0]   beat_q, beat_d;
    logic [1:0]             burst_q, burst_d;
    logic [AXI_DATA_W-1:0]  rdata_q, rdata_d;
    logic [AXI_DATA_W-1:0]  wdata_q, wdata_d;
    logic [StrbW-1:0]       wstrb_q, wstrb_d;
    logic                   rvalid_q, rvalid_d;
    logic                   rlast_q, rlast_d;
    logic                   err_q, err_d;

    logic                   grant_rd, grant_wr;
    logic                   beat_is_last;
    logic                   wr_skip;
    logic [WordAddrW-1:0]   addr_next;

    logic unused_axi;
    assign unused_axi = ^{axi_arsize_i, axi_arprot_i, axi_arlock_i, axi_arcache_i, axi_arqos_i,
                          axi_awsize_i, axi_awprot_i, axi_awlock_i, axi_awcache_i, axi_awqos_i};

    // Contested requests go to the channel that did not win last; idle defaults to read.
    always_comb begin
        if (axi_arvalid_i && axi_awvalid_i) begin
            grant_rd = last_grant_wr_q;
        end else begin
            grant_rd = ~axi_awvalid_i;
        end
        grant_wr = ~grant_rd;
    end

    assign beat_is_last = (beat_q == len_q);
    assign wr_skip      = (wstrb_q == '0);
    assign addr_next    = (burst_q == 2'b00) ? addr_q : addr_q + WordAddrW'(1);

    assign axi_arready_o = (state_q == StIdle) & ~rst_i & grant_rd;
    assign axi_awready_o = (state_q == StIdle) & ~rst_i & grant_wr;
    assign axi_wready_o  = (state_q == StWrData);
    assign axi_bvalid_o  = (state_q == StWrResp);
    assign axi_bresp_o   = {err_q, 1'b0};
    assign axi_bid_o     = id_q;
    assign axi_rid_o     = id_q;
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = 2'b00;
    assign axi_rlast_o   = rlast_q;
    assign axi_rvalid_o  = rvalid_q;

    assign iob_valid_o = (state_q == StRdReq) | ((state_q == StWrReq) & ~wr_skip);
    assign iob_addr_o  = addr_q;
    assign iob_wdata_o = wdata_q;
    assign iob_wstrb_o = (state_q == StWrReq) ? wstrb_q : '0;

    always_comb begin
        state_d         = state_q;
        last_grant_wr_d = last_grant_wr_q;
        id_d            = id_q;
        addr_d          = addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        burst_d         = burst_q;
        rdata_d         = rdata_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        rvalid_d        = rvalid_q;
        rlast_d         = rlast_q;
        err_d           = err_q;

        unique case (state_q)
            StIdle: begin
                if (axi_arvalid_i && grant_rd) begin
                    id_d            = axi_arid_i;
                    addr_d          = axi_araddr_i;
                    len_d           = axi_arlen_i;
                    burst_d         = axi_arburst_i;
                    beat_d          = '0;
                    last_grant_wr_d = 1'b0;
                    state_d         = StRdReq;
                end else if (axi_awvalid_i && grant_wr) begin
                    id_d            = axi_awid_i;
                    addr_d          = axi_awaddr_i;
                    len_d           = axi_awlen_i;
                    burst_d         = axi_awburst_i;
                    beat_d          = '0;
                    last_grant_wr_d = 1'b1;
                    state_d         = StWrData;
                end
            end
            StRdReq: begin
                if (iob_ready_i) state_d = StRdWait;
            end
            StRdWait: begin
                if (iob_rvalid_i) begin
                    rdata_d  = iob_rdata_i;
                    rvalid_d = 1'b1;
                    rlast_d  = beat_is_last;
                    state_d  = StRdResp;
                end
            end
            StRdResp: begin
                if (axi_rready_i) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + AXI_LEN_W'(1);
                        addr_d  = addr_next;
                        state_d = StRdReq;
                    end
                end
            end
            StWrData: begin
                if (axi_wvalid_i) begin
                    wdata_d = axi_wdata_i;
                    wstrb_d = axi_wstrb_i;
                    // Misplaced or missing wlast is reported, but len+1 beats are still taken.
                    if (axi_wlast_i != beat_is_last) err_d = 1'b1;
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                if (iob_ready_i || wr_skip) begin
                    if (beat_is_last) begin
                        state_d = StWrResp;
                    end else begin
                        beat_d  = beat_q + AXI_LEN_W'(1);
                        addr_d  = addr_next;
                        state_d = StWrData;
                    end
                end
            end
            StWrResp: begin
                if (axi_bready_i) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q         <= StIdle;
                last_grant_wr_q <= 1'b1;
                id_q            <= '0;
                addr_q          <= '0;
                len_q           <= '0;
                beat_q          <= '0;
                burst_q         <= '0;
                rdata_q         <= '0;
                wdata_q         <= '0;
                wstrb_q         <= '0;
                rvalid_q        <= 1'b0;
                rlast_q         <= 1'b0;
                err_q           <= 1'b0;
            end else begin
                state_q         <= state_d;
                last_grant_wr_q <= last_grant_wr_d;
                id_q            <= id_d;
                addr_q          <= addr_d;
                len_q           <= len_d;
                beat_q          <= beat_d;
                burst_q         <= burst_d;
                rdata_q         <= rdata_d;
                wdata_q         <= wdata_d;
                wstrb_q         <= wstrb_d;
                rvalid_q        <= rvalid_d;
                rlast_q         <= rlast_d;
                err_q           <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_iob_axi2iob_sub.sv
// Bench for iob_axi2iob_sub: AXI master tasks, a randomised IOB memory responder,
// and expectations derived from burst rules and an address-hashed memory image.
module tb_iob_axi2iob_sub;

    localparam int unsigned IdW   = 1;
    localparam int unsigned AddrW = 32;
    localparam int unsigned WaW   = AddrW - 2;

    logic           clk_i, rst_i, cke_i;
    logic [WaW-1:0] axi_araddr_i, axi_awaddr_i;
    logic [IdW-1:0] axi_arid_i, axi_awid_i, axi_rid_o, axi_bid_o;
    logic [7:0]     axi_arlen_i, axi_awlen_i;
    logic [1:0]     axi_arburst_i, axi_awburst_i, axi_rresp_o, axi_bresp_o;
    logic [2:0]     axi_arsize_i, axi_arprot_i, axi_awsize_i, axi_awprot_i;
    logic           axi_arlock_i, axi_awlock_i;
    logic [3:0]     axi_arcache_i, axi_arqos_i, axi_awcache_i, axi_awqos_i;
    logic           axi_arvalid_i, axi_arready_o, axi_awvalid_i, axi_awready_o;
    logic [31:0]    axi_rdata_o, axi_wdata_i;
    logic           axi_rlast_o, axi_rvalid_o, axi_rready_i;
    logic [3:0]     axi_wstrb_i;
    logic           axi_wlast_i, axi_wvalid_i, axi_wready_o;
    logic           axi_bvalid_o, axi_bready_i;
    logic           iob_valid_o, iob_ready_i, iob_rvalid_i;
    logic [WaW-1:0] iob_addr_o;
    logic [31:0]    iob_wdata_o, iob_rdata_i;
    logic [3:0]     iob_wstrb_o;

    iob_axi2iob_sub #(
        .AXI_ID_W  (IdW),
        .AXI_ADDR_W(AddrW),
        .AXI_DATA_W(32),
        .AXI_LEN_W (8)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i),
        .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i),
        .axi_arburst_i(axi_arburst_i), .axi_arsize_i(axi_arsize_i), .axi_arprot_i(axi_arprot_i),
        .axi_arlock_i(axi_arlock_i), .axi_arcache_i(axi_arcache_i), .axi_arqos_i(axi_arqos_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o), .axi_rid_o(axi_rid_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i),
        .axi_awburst_i(axi_awburst_i), .axi_awsize_i(axi_awsize_i), .axi_awprot_i(axi_awprot_i),
        .axi_awlock_i(axi_awlock_i), .axi_awcache_i(axi_awcache_i), .axi_awqos_i(axi_awqos_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i)
    );

    typedef struct packed {
        logic [WaW-1:0] addr;
        logic [31:0]    data;
        logic [3:0]     strb;
    } iob_req_t;

    iob_req_t    iob_log[$];
    int          n_total, n_bad;
    int          rv_extra;
    int          hs_seq, ar_seq, aw_seq;
    logic [31:0] wr_data[16];
    logic [3:0]  wr_strb[16];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory image seen through the IOB port (reads only).
    function automatic logic [31:0] rd_word(input logic [WaW-1:0] a);
        if (a == 30'h100) return 32'hDEADBEEF;
        return {a, 2'b01} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [WaW-1:0] beat_addr(input logic [WaW-1:0] a, input logic [1:0] burst,
                                                 input int i);
        return (burst == 2'b00) ? a : a + 30'(i);
    endfunction

    // IOB responder: random ready, read data 1..3+rv_extra cycles after accept.
    initial begin : iob_slave
        logic           acc, was_rd, was_rst, was_cke, stall;
        logic [WaW-1:0] a, rv_addr, st_a;
        logic [31:0]    st_d;
        int             rv_cnt;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        rv_cnt = -1; stall = 1'b0; rv_addr = '0; st_a = '0; st_d = '0;
        forever begin
            @(negedge clk_i);
            was_cke = cke_i;
            was_rst = rst_i;
            acc     = iob_valid_o && iob_ready_i;
            a       = iob_addr_o;
            was_rd  = (iob_wstrb_o == 4'h0);
            if (!was_rst) begin
                check_eq("iob_while_r", 32'(iob_valid_o && axi_rvalid_o), 0);
                if (stall && iob_valid_o) begin
                    check_eq("iob_addr_stable", 32'(iob_addr_o), 32'(st_a));
                    check_eq("iob_wdata_stable", iob_wdata_o, st_d);
                end
            end
            stall = !was_rst && iob_valid_o && !iob_ready_i;
            st_a  = iob_addr_o;
            st_d  = iob_wdata_o;
            if (was_cke && !was_rst && acc) iob_log.push_back('{iob_addr_o, iob_wdata_o, iob_wstrb_o});
            @(posedge clk_i); #1;
            if (was_rst && was_cke) begin
                rv_cnt = -1;
                iob_rvalid_i = 1'b0;
            end else if (was_cke) begin
                iob_rvalid_i = 1'b0;
                if (acc && was_rd) begin
                    rv_addr = a;
                    rv_cnt  = $urandom_range(0, 2) + rv_extra;
                end
                if (rv_cnt == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rd_word(rv_addr);
                    rv_cnt       = -1;
                end else if (rv_cnt > 0) begin
                    rv_cnt--;
                end
                iob_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic ar_send(input logic [IdW-1:0] id, input logic [WaW-1:0] a, input int len,
                           input logic [1:0] burst);
        int cyc = 0;
        @(posedge clk_i); #1;
        axi_arid_i = id; axi_araddr_i = a; axi_arlen_i = 8'(len); axi_arburst_i = burst;
        axi_arsize_i = 3'($urandom); axi_arvalid_i = 1'b1;
        do begin @(negedge clk_i); cyc++; end while (!axi_arready_o && cyc < 300);
        check_eq("ar_handshake", 32'(axi_arready_o), 1);
        @(posedge clk_i); #1;
        axi_arvalid_i = 1'b0;
        ar_seq = hs_seq++;
    endtask

    // rmode: 0 random rready, 1 toggling, 2 always ready
    task automatic axi_read(input logic [IdW-1:0] id, input logic [WaW-1:0] a, input int len,
                            input logic [1:0] burst, input int rmode, input bit chk_log);
        int   beat = 0, cyc = 0;
        logic tog = 1'b0;
        if (chk_log) iob_log.delete();
        ar_send(id, a, len, burst);
        while (beat <= len && cyc < 3000) begin
            axi_rready_i = (rmode == 0) ? 1'($urandom_range(0, 1)) : (rmode == 1) ? tog : 1'b1;
            tog = ~tog;
            @(negedge clk_i); cyc++;
            if (axi_rvalid_o && axi_rready_i) begin
                check_eq("r_data", axi_rdata_o, rd_word(beat_addr(a, burst, beat)));
                check_eq("r_id", 32'(axi_rid_o), 32'(id));
                check_eq("r_resp", 32'(axi_rresp_o), 0);
                check_eq("r_last", 32'(axi_rlast_o), 32'(beat == len));
                beat++;
            end
            @(posedge clk_i); #1;
        end
        axi_rready_i = 1'b0;
        check_eq("r_beats", 32'(beat), 32'(len + 1));
        if (chk_log) begin
            check_eq("r_iob_cnt", 32'(iob_log.size()), 32'(len + 1));
            for (int i = 0; i < iob_log.size() && i <= len; i++) begin
                check_eq("r_iob_addr", 32'(iob_log[i].addr), 32'(beat_addr(a, burst, i)));
                check_eq("r_iob_strb", 32'(iob_log[i].strb), 0);
            end
        end
    endtask

    // Data/strobes come from wr_data/wr_strb; wlast is driven on beat wlast_at.
    task automatic axi_write(input logic [IdW-1:0] id, input logic [WaW-1:0] a, input int len,
                             input logic [1:0] burst, input int wlast_at, input bit chk_log);
        int cyc = 0, n = 0;
        bit got = 1'b0;
        if (chk_log) iob_log.delete();
        @(posedge clk_i); #1;
        axi_awid_i = id; axi_awaddr_i = a; axi_awlen_i = 8'(len); axi_awburst_i = burst;
        axi_awsize_i = 3'($urandom); axi_awvalid_i = 1'b1;
        do begin @(negedge clk_i); cyc++; end while (!axi_awready_o && cyc < 300);
        check_eq("aw_handshake", 32'(axi_awready_o), 1);
        @(posedge clk_i); #1;
        axi_awvalid_i = 1'b0;
        aw_seq = hs_seq++;
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
            axi_wdata_i = wr_data[i]; axi_wstrb_i = wr_strb[i];
            axi_wlast_i = (i == wlast_at); axi_wvalid_i = 1'b1;
            cyc = 0;
            do begin @(negedge clk_i); cyc++; end while (!axi_wready_o && cyc < 300);
            check_eq("w_handshake", 32'(axi_wready_o), 1);
            @(posedge clk_i); #1;
            axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
        end
        cyc = 0;
        while (!got && cyc < 300) begin
            axi_bready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i); cyc++;
            if (axi_bvalid_o && axi_bready_i) begin
                check_eq("b_resp", 32'(axi_bresp_o), (wlast_at != len) ? 32'd2 : 32'd0);
                check_eq("b_id", 32'(axi_bid_o), 32'(id));
                got = 1'b1;
            end
            @(posedge clk_i); #1;
        end
        axi_bready_i = 1'b0;
        check_eq("b_seen", 32'(got), 1);
        if (chk_log) begin
            for (int i = 0; i <= len; i++) begin
                if (wr_strb[i] != 4'h0) begin
                    if (n < iob_log.size()) begin
                        check_eq("w_iob_addr", 32'(iob_log[n].addr), 32'(beat_addr(a, burst, i)));
                        check_eq("w_iob_data", iob_log[n].data, wr_data[i]);
                        check_eq("w_iob_strb", 32'(iob_log[n].strb), 32'(wr_strb[i]));
                    end
                    n++;
                end
            end
            check_eq("w_iob_cnt", 32'(iob_log.size()), 32'(n));
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin : main
        int          cyc, r_len, r_wl;
        logic        seen;
        logic [WaW-1:0] r_addr;
        logic [1:0]  r_burst;
        logic [IdW-1:0] r_id;
        n_total = 0; n_bad = 0; rv_extra = 0; hs_seq = 0; ar_seq = 0; aw_seq = 0;
        rst_i = 1'b1; cke_i = 1'b1;
        axi_araddr_i = '0; axi_arid_i = '0; axi_arlen_i = '0; axi_arburst_i = '0;
        axi_arsize_i = '0; axi_arprot_i = '0; axi_arlock_i = '0; axi_arcache_i = '0;
        axi_arqos_i = '0; axi_arvalid_i = 1'b0; axi_rready_i = 1'b0;
        axi_awaddr_i = '0; axi_awid_i = '0; axi_awlen_i = '0; axi_awburst_i = '0;
        axi_awsize_i = '0; axi_awprot_i = '0; axi_awlock_i = '0; axi_awcache_i = '0;
        axi_awqos_i = '0; axi_awvalid_i = 1'b0;
        axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0;
        axi_bready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin wr_data[i] = '0; wr_strb[i] = '0; end

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_handshakes", 32'({iob_valid_o, axi_rvalid_o, axi_bvalid_o, axi_arready_o,
                                        axi_awready_o, axi_wready_o}), 0);
        check_eq("rst_rdata", axi_rdata_o, 0);
        check_eq("rst_misc", 32'({axi_rresp_o, axi_bresp_o, axi_rid_o, axi_bid_o, axi_rlast_o,
                                  iob_wstrb_o}), 0);
        check_eq("rst_iob_addr", 32'(iob_addr_o), 0);
        check_eq("rst_iob_wdata", iob_wdata_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_arready", 32'(axi_arready_o), 1);

        // Directed transactions
        axi_read(1'b1, 30'h100, 0, 2'b01, 2, 1'b1);
        axi_read(1'b0, 30'h3FFFFFFE, 3, 2'b01, 1, 1'b1);
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'b0011;
        wr_data[1] = 32'h0;        wr_strb[1] = 4'b0000;
        axi_write(1'b1, 30'h20, 1, 2'b01, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        axi_write(1'b0, 30'h40, 2, 2'b01, 0, 1'b1);
        axi_write(1'b0, 30'h80, 2, 2'b01, 2, 1'b1);
        axi_read(1'b1, 30'h55, 2, 2'b00, 0, 1'b1);
        wr_strb[0] = 4'b1000; wr_strb[1] = 4'b0100;
        axi_write(1'b1, 30'h66, 1, 2'b00, 1, 1'b1);

        // Arbitration: contested after reset goes to read, alternates afterwards
        do_reset();
        fork
            axi_read(1'b0, 30'h10, 1, 2'b01, 0, 1'b0);
            axi_write(1'b1, 30'h30, 0, 2'b01, 0, 1'b0);
        join
        check_eq("arb_rd_first", 32'(ar_seq < aw_seq), 1);
        axi_read(1'b1, 30'h11, 0, 2'b01, 2, 1'b1);
        fork
            axi_read(1'b0, 30'h12, 0, 2'b01, 0, 1'b0);
            axi_write(1'b1, 30'h31, 0, 2'b01, 0, 1'b0);
        join
        check_eq("arb_wr_first", 32'(aw_seq < ar_seq), 1);

        // Reset while waiting for IOB read data
        rv_extra = 30;
        iob_log.delete();
        ar_send(1'b1, 30'h200, 3, 2'b01);
        cyc = 0;
        while (iob_log.size() == 0 && cyc < 100) begin @(negedge clk_i); cyc++; end
        check_eq("rst_mid_acc", 32'(iob_log.size()), 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_mid_valids", 32'({iob_valid_o, axi_rvalid_o, axi_bvalid_o, axi_arready_o,
                                        axi_awready_o, axi_wready_o}), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; rv_extra = 0; axi_rready_i = 1'b1; seen = 1'b0;
        repeat (20) begin @(negedge clk_i); seen |= axi_rvalid_o; end
        axi_rready_i = 1'b0;
        check_eq("rst_mid_no_r", 32'(seen), 0);
        axi_read(1'b0, 30'h300, 1, 2'b01, 2, 1'b1);

        // Clock enable low while an R beat is pending
        ar_send(1'b1, 30'h123, 0, 2'b01);
        cyc = 0;
        while (!axi_rvalid_o && cyc < 100) begin @(negedge clk_i); cyc++; end
        check_eq("cke_rvalid", 32'(axi_rvalid_o), 1);
        @(posedge clk_i); #1;
        cke_i = 1'b0; axi_rready_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check_eq("cke_hold_valid", 32'(axi_rvalid_o), 1);
            check_eq("cke_hold_data", axi_rdata_o, rd_word(30'h123));
            @(posedge clk_i); #1;
        end
        cke_i = 1'b1;
        @(negedge clk_i);
        check_eq("cke_resume", 32'(axi_rvalid_o && axi_rlast_o), 1);
        @(posedge clk_i); #1;
        axi_rready_i = 1'b0;
        @(negedge clk_i);
        check_eq("cke_consumed", 32'(axi_rvalid_o), 0);

        // Random traffic
        for (int t = 0; t < 30; t++) begin
            r_len   = $urandom_range(0, 7);
            r_addr  = 30'($urandom);
            if ($urandom_range(0, 3) == 0) r_addr = 30'h3FFFFFFC | 30'($urandom_range(0, 3));
            r_burst = 2'($urandom);
            r_id    = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                axi_read(r_id, r_addr, r_len, r_burst, 0, 1'b1);
            end else begin
                for (int i = 0; i <= r_len; i++) begin
                    wr_data[i] = $urandom;
                    wr_strb[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                end
                r_wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_len) : r_len;
                axi_write(r_id, r_addr, r_len, r_burst, r_wl, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
